// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: ALU command encodings, status
// register bit positions, execute-sequencer FSM states and the ID/EXE bundle.
package core_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        b;
        logic        s;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
    } id_exe_t;

    // A bubble is a non-instruction with every control and data field cleared.
    function automatic id_exe_t bubble_bundle();
        id_exe_t bub;
        bub = '0;
        return bub;
    endfunction

endpackage

// File: rtl/exe_sequencer_id_exe_reg.sv
// Freezable pipeline register with synchronous bubble-load and async reset.
module id_exe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] bubble_val,
    output logic [WIDTH-1:0] q
);

    // Pipeline register: hold wins over bubble, bubble wins over new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (hold) begin
            q <= q;
        end else if (bubble) begin
            q <= bubble_val;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe_sequencer.sv
// ID/EXE pipeline register, status register and branch-squash sequencer in
// front of the execute stage.
module exe_sequencer
    import core_pkg::*;
#(
    parameter int FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        id_valid,
    input  logic [3:0]  id_exe_cmd,
    input  logic        id_mem_r_en,
    input  logic        id_mem_w_en,
    input  logic        id_wb_en,
    input  logic        id_b,
    input  logic        id_s,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_val_rn,
    input  logic [31:0] id_val_rm,
    input  logic        id_imm,
    input  logic [11:0] id_shift_operand,
    input  logic [23:0] id_signed_imm_24,
    input  logic [3:0]  id_dest,
    input  logic [3:0]  alu_status,
    output logic        exe_valid,
    output logic [3:0]  exe_exe_cmd,
    output logic        exe_mem_r_en,
    output logic        exe_mem_w_en,
    output logic        exe_wb_en,
    output logic        exe_b,
    output logic        exe_s,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_val_rn,
    output logic [31:0] exe_val_rm,
    output logic        exe_imm,
    output logic [11:0] exe_shift_operand,
    output logic [23:0] exe_signed_imm_24,
    output logic [3:0]  exe_dest,
    output logic [3:0]  sr,
    output logic        branch_taken,
    output logic        flush
);

    // Counter holds the FLUSH-state cycles still to go; the resolution cycle
    // itself supplies the first squash slot.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    seq_state_t  state_r;
    seq_state_t  state_next_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_next_s;
    logic [3:0]  sr_r;
    logic        branch_taken_s;
    logic        flush_s;
    logic        load_bubble_s;
    id_exe_t     id_bus_s;
    id_exe_t     exe_bus_r;

    assign branch_taken_s = exe_bus_r.valid & exe_bus_r.b & ~freeze;

    // Gather ID-stage fields into the bundle presented to the register.
    always_comb begin
        id_bus_s               = bubble_bundle();
        id_bus_s.valid         = id_valid & ~branch_taken_s;
        id_bus_s.exe_cmd       = id_exe_cmd;
        id_bus_s.mem_r_en      = id_mem_r_en;
        id_bus_s.mem_w_en      = id_mem_w_en;
        id_bus_s.wb_en         = id_wb_en;
        id_bus_s.b             = id_b;
        id_bus_s.s             = id_s;
        id_bus_s.pc            = id_pc;
        id_bus_s.val_rn        = id_val_rn;
        id_bus_s.val_rm        = id_val_rm;
        id_bus_s.imm           = id_imm;
        id_bus_s.shift_operand = id_shift_operand;
        id_bus_s.signed_imm_24 = id_signed_imm_24;
        id_bus_s.dest          = id_dest;
    end

    // Next-state, counter and squash control.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        load_bubble_s = 1'b0;
        flush_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                flush_s = branch_taken_s;
                if (branch_taken_s) begin
                    load_bubble_s = 1'b1;
                    if (FLUSH_LOAD != 3'd0) begin
                        state_next_s = ST_FLUSH;
                        cnt_next_s   = FLUSH_LOAD;
                    end else begin
                        cnt_next_s   = 3'd0;
                    end
                end else begin
                    load_bubble_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                flush_s       = 1'b1;
                load_bubble_s = 1'b1;
                if (freeze) begin
                    cnt_next_s = cnt_r;
                end else if (cnt_r <= 3'd1) begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = 3'd0;
                end else begin
                    cnt_next_s   = cnt_r - 3'd1;
                end
            end
            default: begin
                state_next_s  = ST_RUN;
                cnt_next_s    = 3'd0;
                load_bubble_s = 1'b1;
                flush_s       = 1'b0;
            end
        endcase
    end

    // FSM state and flush counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else if (freeze) begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Status register: only a real, non-frozen S instruction writes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r <= 4'b0000;
        end else if (exe_bus_r.valid && exe_bus_r.s && !freeze) begin
            sr_r <= alu_status;
        end else begin
            sr_r <= sr_r;
        end
    end

    id_exe_reg #(
        .WIDTH($bits(id_exe_t))
    ) u_id_exe_reg (
        .clk        (clk),
        .rst        (rst),
        .hold       (freeze),
        .bubble     (load_bubble_s),
        .d          (id_bus_s),
        .bubble_val (bubble_bundle()),
        .q          (exe_bus_r)
    );

    assign exe_valid         = exe_bus_r.valid;
    assign exe_exe_cmd       = exe_bus_r.exe_cmd;
    assign exe_mem_r_en      = exe_bus_r.mem_r_en;
    assign exe_mem_w_en      = exe_bus_r.mem_w_en;
    assign exe_wb_en         = exe_bus_r.wb_en;
    assign exe_b             = exe_bus_r.b;
    assign exe_s             = exe_bus_r.s;
    assign exe_pc            = exe_bus_r.pc;
    assign exe_val_rn        = exe_bus_r.val_rn;
    assign exe_val_rm        = exe_bus_r.val_rm;
    assign exe_imm           = exe_bus_r.imm;
    assign exe_shift_operand = exe_bus_r.shift_operand;
    assign exe_signed_imm_24 = exe_bus_r.signed_imm_24;
    assign exe_dest          = exe_bus_r.dest;
    assign sr                = sr_r;
    assign branch_taken      = branch_taken_s;
    assign flush             = flush_s;

endmodule

// File: tb/tb_exe_sequencer.sv
// Directed and randomized bench for exe_sequencer against a slot-counting
// reference model of the execute-stage sequencing rules.
module tb_exe_sequencer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_exe_cmd = 4'd0;
    logic        id_mem_r_en = 1'b0, id_mem_w_en = 1'b0, id_wb_en = 1'b0;
    logic        id_b = 1'b0, id_s = 1'b0, id_imm = 1'b0;
    logic [31:0] id_pc = 32'd0, id_val_rn = 32'd0, id_val_rm = 32'd0;
    logic [11:0] id_shift_operand = 12'd0;
    logic [23:0] id_signed_imm_24 = 24'd0;
    logic [3:0]  id_dest = 4'd0;
    logic [3:0]  alu_status = 4'd0;

    logic        exe_valid, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_imm;
    logic [3:0]  exe_exe_cmd, exe_dest, sr;
    logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
    logic [11:0] exe_shift_operand;
    logic [23:0] exe_signed_imm_24;
    logic        branch_taken, flush;

    int tests = 0;
    int fails = 0;

    // Reference model: what EXE should hold, the SR, and squash slots left.
    logic         m_valid;
    logic [145:0] m_fields;
    logic [3:0]   m_sr;
    int           m_squash;

    exe_sequencer #(.FLUSH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
        .id_exe_cmd(id_exe_cmd), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .id_wb_en(id_wb_en), .id_b(id_b), .id_s(id_s), .id_pc(id_pc),
        .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
        .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
        .id_dest(id_dest), .alu_status(alu_status), .exe_valid(exe_valid),
        .exe_exe_cmd(exe_exe_cmd), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
        .exe_wb_en(exe_wb_en), .exe_b(exe_b), .exe_s(exe_s), .exe_pc(exe_pc),
        .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .exe_imm(exe_imm),
        .exe_shift_operand(exe_shift_operand), .exe_signed_imm_24(exe_signed_imm_24),
        .exe_dest(exe_dest), .sr(sr), .branch_taken(branch_taken), .flush(flush)
    );

    always #5 clk = ~clk;

    // Field layout: cmd[145:142] r[141] w[140] wb[139] b[138] s[137] pc[136:105]
    // rn[104:73] rm[72:41] imm[40] shift[39:28] simm[27:4] dest[3:0]
    function automatic logic [145:0] mk(input logic [3:0] cmd, input logic b, input logic s,
                                        input logic [31:0] rn, input logic [3:0] dest);
        logic [145:0] f;
        f = '0;
        f[145:142] = cmd;
        f[138]     = b;
        f[137]     = s;
        f[104:73]  = rn;
        f[3:0]     = dest;
        return f;
    endfunction

    function automatic logic [145:0] rnd_fields();
        logic [145:0] f;
        f = {$urandom, $urandom, $urandom, $urandom, $urandom, 18'($urandom)};
        f[138] = ($urandom_range(0, 5) == 0);
        return f;
    endfunction

    task automatic check(input string tag, input logic [145:0] obs, input logic [145:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [145:0] dut_fields();
        return {exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_pc,
                exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand, exe_signed_imm_24, exe_dest};
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_fields = '0;
        m_sr     = 4'd0;
        m_squash = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".exe_valid"}, 146'(exe_valid), 146'(m_valid));
        check({tag, ".fields"}, dut_fields(), m_fields);
        check({tag, ".sr"}, 146'(sr), 146'(m_sr));
    endtask

    // One clock: drive, check the combinational outputs, step the model, check flops.
    task automatic cycle(input logic v, input logic [145:0] f, input logic fz, input logic [3:0] alu);
        logic bt;
        id_valid = v;
        {id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s, id_pc, id_val_rn,
         id_val_rm, id_imm, id_shift_operand, id_signed_imm_24, id_dest} = f;
        freeze = fz;
        alu_status = alu;
        #1;
        bt = m_valid & m_fields[138] & ~fz;
        check("branch_taken", 146'(branch_taken), 146'(bt));
        check("flush", 146'(flush), 146'((m_squash > 0) | bt));
        if (!fz) begin
            if (m_valid && m_fields[137]) m_sr = alu;
            if (bt) begin
                m_valid = 1'b0; m_fields = '0; m_squash = DEPTH - 1;
            end else if (m_squash > 0) begin
                m_valid = 1'b0; m_fields = '0; m_squash--;
            end else begin
                m_valid = v; m_fields = f;
            end
        end
        @(posedge clk);
        #1;
        check_regs("cycle");
    endtask

    initial begin
        model_reset();
        #12;
        check_regs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Pass-through
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b0, 32'h5, 4'd3), 1'b0, 4'd0);
        check("pass.cmd", 146'(exe_exe_cmd), 146'(4'b0010));
        check("pass.rn", 146'(exe_val_rn), 146'(32'h5));
        check("pass.dest", 146'(exe_dest), 146'(4'd3));

        // SR update, then non-S leaves SR alone
        cycle(1'b1, mk(4'b0100, 1'b0, 1'b1, 32'h7, 4'd1), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0011, 1'b0, 1'b0, 32'h8, 4'd2), 1'b0, 4'b0110);
        check("sr.s_set", 146'(sr), 146'(4'b0110));
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b0, 32'h9, 4'd4), 1'b0, 4'b1111);
        check("sr.s_clear", 146'(sr), 146'(4'b0110));

        // Branch: two squashed slots, third younger instruction executes
        cycle(1'b1, mk(4'b0000, 1'b1, 1'b0, 32'h0, 4'd0), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0001, 1'b0, 1'b0, 32'hA, 4'd10), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0001, 1'b0, 1'b0, 32'hB, 4'd11), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0001, 1'b0, 1'b0, 32'hC, 4'd12), 1'b0, 4'd0);
        check("branch.third", 146'({exe_valid, exe_dest}), 146'({1'b1, 4'd12}));

        // Freeze for three cycles in the middle of a flush
        cycle(1'b1, mk(4'b0000, 1'b1, 1'b0, 32'h0, 4'd0), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0001, 1'b0, 1'b0, 32'h1, 4'd5), 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(4'b0001, 1'b0, 1'b0, 32'h2, 4'd6), 1'b1, 4'd0);
        cycle(1'b1, mk(4'b0001, 1'b0, 1'b0, 32'h3, 4'd7), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0001, 1'b0, 1'b0, 32'h4, 4'd8), 1'b0, 4'd0);
        check("frzflush.resume", 146'({exe_valid, exe_dest}), 146'({1'b1, 4'd8}));

        // Freeze with an S instruction in EXE
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b1, 32'h1, 4'd1), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b0, 32'h2, 4'd2), 1'b1, 4'b1001);
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b0, 32'h2, 4'd2), 1'b1, 4'b1001);
        check("frz_s.held", 146'(sr), 146'(4'b0110));
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b0, 32'h2, 4'd2), 1'b0, 4'b1001);
        check("frz_s.release", 146'(sr), 146'(4'b1001));

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), rnd_fields(), ($urandom_range(0, 4) == 0), 4'($urandom));

        // Asynchronous reset mid-stream with a valid instruction and SR=1010
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b1, 32'h1, 4'd1), 1'b0, 4'd0);
        cycle(1'b1, mk(4'b0010, 1'b0, 1'b0, 32'h1, 4'd2), 1'b0, 4'b1010);
        check("prerst.sr", 146'({exe_valid, sr}), 146'({1'b1, 4'b1010}));
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_regs("async_rst");
        check("async_rst.flush", 146'({branch_taken, flush}), 146'(2'b00));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++)
            cycle(1'($urandom_range(0, 1)), rnd_fields(), ($urandom_range(0, 4) == 0), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
